// File: rtl/utils.sv
// Shared project constants used as defaults by the serial peripherals.
package utils;
    localparam int CLK_PER_HALF_BIT = 4;
endpackage

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// start-glitch rejection, break hold-off and a show-ahead RX FIFO.
module uart_rx_fifo #(
    parameter int CLK_PER_HALF_BIT = utils::CLK_PER_HALF_BIT,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            rxd,
    output logic [DATA_BITS-1:0]            rdata,
    output logic                            rperr,
    output logic                            rferr,
    output logic                            rvalid,
    input  logic                            rready,
    output logic                            overrun,
    input  logic                            overrun_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);

    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int FW = DATA_BITS + 2;

    localparam logic [CW-1:0] C_HM1 = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] C_H   = CW'(CLK_PER_HALF_BIT);
    localparam logic [CW-1:0] C_HP1 = CW'(CLK_PER_HALF_BIT + 1);
    localparam logic [CW-1:0] C_END = CW'(2 * CLK_PER_HALF_BIT - 1);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]           sync;
    logic                 rxs;
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           bit_idx, bit_n;
    logic                 s0, s0_n, s1, s1_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic                 ferr, ferr_n;
    logic                 vote, at_vote, bit_end, frame_ferr;
    logic                 push_req;
    logic [FW-1:0]        push_word;

    assign rxs = sync[1];

    // Third sample is taken live at cnt = H+1, so the decision uses no extra flop.
    assign vote       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign at_vote    = (cnt == C_HP1);
    assign bit_end    = (cnt == C_END);
    assign frame_ferr = ferr | ~vote;
    assign push_word  = {frame_ferr, perr, shreg};

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rstn) begin
            sync    <= 2'b11;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            sync    <= {sync[0], rxd};
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            s0      <= s0_n;
            s1      <= s1_n;
            shreg   <= shreg_n;
            perr    <= perr_n;
            ferr    <= ferr_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_n  = state;
        cnt_n    = cnt;
        bit_n    = bit_idx;
        s0_n     = s0;
        s1_n     = s1;
        shreg_n  = shreg;
        perr_n   = perr;
        ferr_n   = ferr;
        push_req = 1'b0;

        if (state != S_IDLE && state != S_BREAK) begin
            cnt_n = bit_end ? '0 : cnt + CW'(1);
            if (cnt == C_HM1) s0_n = rxs;
            if (cnt == C_H)   s1_n = rxs;
        end

        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                bit_n  = '0;
                perr_n = 1'b0;
                ferr_n = 1'b0;
                if (!rxs) begin
                    state_n = S_START;
                    cnt_n   = CW'(1);
                end
            end
            S_START: begin
                if (at_vote && vote) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else if (bit_end) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                end
            end
            S_DATA: begin
                if (at_vote) shreg_n = {vote, shreg[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_idx == LAST_DATA) begin
                        bit_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_vote) perr_n = ((^shreg) ^ vote) != PAR_ODD;
                if (bit_end) begin
                    state_n = S_STOP;
                    bit_n   = '0;
                end
            end
            S_STOP: begin
                // The last stop bit ends at its vote so the next start edge is
                // caught with half a bit of margin.
                if (at_vote) begin
                    if (bit_idx == LAST_STOP) begin
                        push_req = 1'b1;
                        state_n  = frame_ferr ? S_BREAK : S_IDLE;
                        cnt_n    = '0;
                        bit_n    = '0;
                    end else begin
                        ferr_n = frame_ferr;
                    end
                end else if (bit_end) begin
                    bit_n = bit_idx + 3'd1;
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rxs) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                bit_n   = '0;
            end
        endcase
    end

    logic [FW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          full, do_pop, do_push;
    logic [FW-1:0] head;

    assign full    = (count == LW'(FIFO_DEPTH));
    assign rvalid  = (count != '0);
    assign do_pop  = rvalid & rready;
    assign do_push = push_req & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Storage is unreset, so the head is gated to read as zero while empty.
    assign rdata = rvalid ? head[DATA_BITS-1:0] : '0;
    assign rperr = rvalid & head[DATA_BITS];
    assign rferr = rvalid & head[DATA_BITS+1];
    assign level = count;

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (overrun_clr)
                overrun <= 1'b0;
            else if (push_req && !do_push)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo: three configurations
// (8N1/16, 8E1/4, 6O2/8) checked against a queue-based frame model.
module tb_uart_rx_fifo;

    localparam int P_H     [3] = '{4, 4, 3};
    localparam int P_DB    [3] = '{8, 8, 6};
    localparam int P_PAR   [3] = '{0, 1, 2};
    localparam int P_SB    [3] = '{1, 1, 2};
    localparam int P_DEPTH [3] = '{16, 4, 8};

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rxd_v [3];
    logic rready_v [3];
    logic clr_v [3];

    logic [7:0] rdata_a, rdata_b;
    logic [5:0] rdata_c;
    logic [4:0] level_a;
    logic [2:0] level_b;
    logic [3:0] level_c;
    logic       rperr_a, rperr_b, rperr_c, rferr_a, rferr_b, rferr_c;
    logic       rvalid_a, rvalid_b, rvalid_c, ovr_a, ovr_b, ovr_c;

    logic [9:0] head_v [3];
    int         level_v [3];
    logic       rvalid_v [3];
    logic       ovr_v [3];

    int n_checks = 0;
    int n_errors = 0;

    // Model: expected FIFO contents {ferr, perr, data} and sticky overrun.
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] q2 [$];
    logic       mov [3];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_PER_HALF_BIT(P_H[0]), .DATA_BITS(P_DB[0]), .PARITY(P_PAR[0]),
                   .STOP_BITS(P_SB[0]), .FIFO_DEPTH(P_DEPTH[0])) dut_a (
        .clk(clk), .rstn(rstn), .rxd(rxd_v[0]), .rdata(rdata_a), .rperr(rperr_a),
        .rferr(rferr_a), .rvalid(rvalid_a), .rready(rready_v[0]), .overrun(ovr_a),
        .overrun_clr(clr_v[0]), .level(level_a));

    uart_rx_fifo #(.CLK_PER_HALF_BIT(P_H[1]), .DATA_BITS(P_DB[1]), .PARITY(P_PAR[1]),
                   .STOP_BITS(P_SB[1]), .FIFO_DEPTH(P_DEPTH[1])) dut_b (
        .clk(clk), .rstn(rstn), .rxd(rxd_v[1]), .rdata(rdata_b), .rperr(rperr_b),
        .rferr(rferr_b), .rvalid(rvalid_b), .rready(rready_v[1]), .overrun(ovr_b),
        .overrun_clr(clr_v[1]), .level(level_b));

    uart_rx_fifo #(.CLK_PER_HALF_BIT(P_H[2]), .DATA_BITS(P_DB[2]), .PARITY(P_PAR[2]),
                   .STOP_BITS(P_SB[2]), .FIFO_DEPTH(P_DEPTH[2])) dut_c (
        .clk(clk), .rstn(rstn), .rxd(rxd_v[2]), .rdata(rdata_c), .rperr(rperr_c),
        .rferr(rferr_c), .rvalid(rvalid_c), .rready(rready_v[2]), .overrun(ovr_c),
        .overrun_clr(clr_v[2]), .level(level_c));

    always_comb begin
        head_v[0]   = {rferr_a, rperr_a, rdata_a};
        head_v[1]   = {rferr_b, rperr_b, rdata_b};
        head_v[2]   = {rferr_c, rperr_c, 2'b00, rdata_c};
        level_v[0]  = int'(level_a);
        level_v[1]  = int'(level_b);
        level_v[2]  = int'(level_c);
        rvalid_v[0] = rvalid_a;
        rvalid_v[1] = rvalid_b;
        rvalid_v[2] = rvalid_c;
        ovr_v[0]    = ovr_a;
        ovr_v[1]    = ovr_b;
        ovr_v[2]    = ovr_c;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int msize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [9:0] mfront(input int i);
        case (i)
            0:       return (q0.size() > 0) ? q0[0] : 10'h0;
            1:       return (q1.size() > 0) ? q1[0] : 10'h0;
            default: return (q2.size() > 0) ? q2[0] : 10'h0;
        endcase
    endfunction

    task automatic mpush(input int i, input logic [9:0] e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mpop(input int i);
        case (i)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endtask

    task automatic hold(input int i, input logic val, input int cycles);
        rxd_v[i] = val;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: plain; 1: rready for the push cycle only; 2: rready from frame
    // start through the push cycle; 3: overrun_clr during the push cycle.
    // The receiver's view lags rxd by two synchroniser cycles, so the vote of
    // the last stop bit (cnt = H+1) falls on frame cycle 2H*(n-1) + H + 3.
    task automatic send(input int i, input logic [7:0] data, input bit pflip,
                        input logic [1:0] stops, input int mode, input int glitch);
        int         h, n, pushc;
        logic [15:0] bits;
        logic [7:0] d;
        logic       perr, ferr;
        h    = P_H[i];
        d    = data & 8'((1 << P_DB[i]) - 1);
        bits = '0;
        n    = 1;
        for (int k = 0; k < P_DB[i]; k++) begin
            bits[n] = d[k];
            n++;
        end
        perr = 1'b0;
        if (P_PAR[i] != 0) begin
            // Correct bit makes the total XOR 0 (even) or 1 (odd).
            bits[n] = (^d) ^ (P_PAR[i] == 2) ^ pflip;
            perr    = pflip;
            n++;
        end
        ferr = 1'b0;
        for (int k = 0; k < P_SB[i]; k++) begin
            bits[n] = stops[k];
            if (!stops[k]) ferr = 1'b1;
            n++;
        end
        pushc = 2 * h * (n - 1) + h + 3;
        for (int c = 0; c < n * 2 * h; c++) begin
            rxd_v[i]    = bits[c / (2 * h)] ^ logic'(c == glitch);
            rready_v[i] = (mode == 1 && c == pushc) || (mode == 2 && c <= pushc);
            clr_v[i]    = (mode == 3 && c == pushc);
            if (mode == 1 && c == pushc && msize(i) > 0)
                check("head_at_push_pop", head_v[i], mfront(i));
            @(posedge clk);
            #1;
        end
        rready_v[i] = 1'b0;
        clr_v[i]    = 1'b0;
        if (mode == 1 && msize(i) > 0) begin
            mpop(i);
            mpush(i, {ferr, perr, d});
        end else if (msize(i) < P_DEPTH[i]) begin
            mpush(i, {ferr, perr, d});
        end else if (mode != 3) begin
            mov[i] = 1'b1;
        end
        if (mode == 3) mov[i] = 1'b0;
    endtask

    task automatic pop_check(input int i, input string tag);
        check({tag, "_rvalid"}, rvalid_v[i], 1'b1);
        check(tag, head_v[i], mfront(i));
        rready_v[i] = 1'b1;
        @(posedge clk);
        #1;
        rready_v[i] = 1'b0;
        mpop(i);
    endtask

    task automatic check_state(input int i, input string tag);
        check({tag, "_level"}, level_v[i], msize(i));
        check({tag, "_overrun"}, ovr_v[i], mov[i]);
    endtask

    task automatic drain(input int i, input string tag);
        while (msize(i) > 0) pop_check(i, tag);
        check({tag, "_empty"}, rvalid_v[i], 1'b0);
    endtask

    task automatic clear_overrun(input int i);
        clr_v[i] = 1'b1;
        @(posedge clk);
        #1;
        clr_v[i] = 1'b0;
        mov[i]   = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        bit         pf;
        logic [1:0] st;

        for (int i = 0; i < 3; i++) begin
            rxd_v[i]    = 1'b1;
            rready_v[i] = 1'b0;
            clr_v[i]    = 1'b0;
            mov[i]      = 1'b0;
        end
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_rvalid", rvalid_v[i], 1'b0);
            check("reset_head", head_v[i], 10'h0);
            check_state(i, "reset");
        end
        rstn = 1'b1;
        hold(0, 1'b1, 8);

        // 8N1 back-to-back frames.
        send(0, 8'hA5, 0, 2'b11, 0, -1);
        send(0, 8'h3C, 0, 2'b11, 0, -1);
        hold(0, 1'b1, 8);
        check("b2b_level", level_v[0], 2);
        drain(0, "b2b");

        // Even parity: 0x07 with wrong then correct parity bit.
        send(1, 8'h07, 1, 2'b11, 0, -1);
        send(1, 8'h07, 0, 2'b11, 0, -1);
        hold(1, 1'b1, 8);
        check_state(1, "parity");
        drain(1, "parity");

        // Start pulse shorter than half a bit is rejected; receiver stays usable.
        hold(0, 1'b0, P_H[0] - 1);
        hold(0, 1'b1, 32);
        check("short_start_level", level_v[0], 0);
        send(0, 8'h96, 0, 2'b11, 0, -1);
        hold(0, 1'b1, 8);
        drain(0, "after_glitch");

        // One-clock high glitch centred in data bit 3 of 0x00.
        send(0, 8'h00, 0, 2'b11, 0, 4 * 2 * P_H[0] + P_H[0]);
        hold(0, 1'b1, 8);
        drain(0, "data_glitch");

        // Stop bit low followed by a held-low line: one framed-error entry.
        send(0, 8'h3C, 0, 2'b00, 0, -1);
        hold(0, 1'b0, 5 * 2 * P_H[0]);
        hold(0, 1'b1, 16);
        check_state(0, "break");
        drain(0, "break");
        send(0, 8'h55, 0, 2'b11, 0, -1);
        hold(0, 1'b1, 8);
        drain(0, "after_break");

        // Push and pop in one cycle at level 1, then rready high while empty.
        send(0, 8'h11, 0, 2'b11, 0, -1);
        hold(0, 1'b1, 8);
        send(0, 8'h22, 0, 2'b11, 1, -1);
        hold(0, 1'b1, 8);
        check_state(0, "pushpop_mid");
        drain(0, "pushpop_mid");
        send(0, 8'h33, 0, 2'b11, 2, -1);
        hold(0, 1'b1, 8);
        check_state(0, "push_empty_ready");
        drain(0, "push_empty_ready");

        // Depth-4 overflow handling.
        for (int f = 1; f <= 5; f++) begin
            send(1, 8'(f * 8'h13), 0, 2'b11, 0, -1);
            hold(1, 1'b1, 8);
        end
        check_state(1, "overflow");
        check("overflow_head", head_v[1], mfront(1));
        clear_overrun(1);
        check_state(1, "ovr_clr");
        send(1, 8'hC6, 0, 2'b11, 0, -1);
        hold(1, 1'b1, 8);
        check_state(1, "drop6");
        send(1, 8'hD7, 0, 2'b11, 3, -1);
        hold(1, 1'b1, 8);
        check_state(1, "clr_priority");
        send(1, 8'hE8, 0, 2'b11, 1, -1);
        hold(1, 1'b1, 8);
        check_state(1, "full_pushpop");
        drain(1, "overflow");

        // Randomised 6O2 traffic with random pops and overrun clears.
        for (int f = 0; f < 36; f++) begin
            d  = 8'($urandom_range(0, 63));
            pf = ($urandom_range(0, 7) == 0);
            st = 2'b11;
            if ($urandom_range(0, 7) == 0) st = 2'($urandom_range(0, 2));
            send(2, d, pf, st, 0, -1);
            hold(2, 1'b1, 2 * P_H[2] * int'($urandom_range(1, 2)));
            check_state(2, "rnd");
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) begin
                    if (msize(2) > 0) pop_check(2, "rnd_pop");
                end
            end
            if ($urandom_range(0, 9) == 0) clear_overrun(2);
        end
        drain(2, "rnd_drain");

        // Reset in the middle of a frame with entries queued.
        send(1, 8'h21, 0, 2'b11, 0, -1);
        send(1, 8'h42, 0, 2'b11, 0, -1);
        hold(1, 1'b1, 8);
        check("pre_reset_level", level_v[1], 2);
        hold(1, 1'b0, 8);
        hold(1, 1'b1, 8);
        hold(1, 1'b0, 8);
        hold(1, 1'b1, 8);
        rstn = 1'b0;
        hold(1, 1'b1, 3);
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) mov[i] = 1'b0;
        rstn = 1'b1;
        hold(1, 1'b1, 200);
        check_state(1, "mid_reset");
        check("mid_reset_rvalid", rvalid_v[1], 1'b0);
        send(1, 8'h5A, 0, 2'b11, 0, -1);
        hold(1, 1'b1, 8);
        drain(1, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Adds configurable data width, parity and stop bits, a 2-flop input synchroniser, 3-sample majority voting and start-glitch rejection.
- Received frames go into a show-ahead RX FIFO with a valid/ready output. Sits between the board RX pin and the core's MMIO/input-stream logic.

Parameters:
- CLK_PER_HALF_BIT, utils::CLK_PER_HALF_BIT: clocks per half bit period (H). Legal values are >= 2.
- DATA_BITS, 8: data bits per frame. Legal range 5..8.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries. Must be a power of 2, >= 2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- rxd  in  1  asynchronous serial input, idle high
- rdata  out  DATA_BITS  data at FIFO head
- rperr  out  1  parity error flag of head entry
- rferr  out  1  framing error flag of head entry
- rvalid  out  1  FIFO non-empty
- rready  in  1  consumer pops head when rvalid & rready
- overrun  out  1  sticky: a frame was dropped because the FIFO was full
- overrun_clr  in  1  clears overrun
- level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset: rstn, synchronous, active-low; clock clk. While in reset:
  - state is IDLE, bit counter is 0, sync flops are 1.
  - FIFO is empty: rvalid=0, level=0, rdata/rperr/rferr=0.
  - overrun=0.
  - Reset mid-frame discards the partial frame.
- Synchroniser: rxd passes through 2 flops to give rxs. All sampling uses rxs.
- Bit timing:
  - cnt runs 0..2H-1 within each bit and wraps to 0 at the next bit.
  - rxs is sampled at cnt = H-1, H and H+1. The bit value is the majority of the three, decided at cnt = H+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: cnt held at 0. When rxs==0, go to START; that cycle counts as cnt=0.
  - START: if the vote at H+1 is 1, this is a glitch: return to IDLE and push nothing. Otherwise go to DATA at cnt=2H-1.
  - DATA: shift in LSB first. After DATA_BITS bits, go to PARITY if PARITY!=0, else STOP.
  - PARITY: perr = (XOR of data bits ^ voted parity bit) != (PARITY==2 ? 1 : 0). That is, even parity expects an XOR of 0 and odd parity expects 1.
  - STOP: one or two stop bits.
    - ferr = any voted stop bit is 0.
    - With 2 stop bits, the first stop bit runs a full bit period.
    - At cnt=H+1 of the last stop bit, push {ferr, perr, data}. perr is 0 when PARITY==0.
    - Then go to IDLE if ferr==0, else BREAK.
  - BREAK: wait until rxs==1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Latency: the push happens at cnt=H+1 of the last stop bit. rvalid, rdata, level and overrun update on the next edge.
- FIFO:
  - Show-ahead: rdata, rperr and rferr are valid whenever rvalid=1 and stay stable until popped.
  - Pop when rvalid & rready.
- Boundary conditions:
  - Push while full with no pop: frame dropped, overrun set, level unchanged.
  - Push and pop in the same cycle while full: both happen, overrun stays unchanged.
  - Push and pop in the same cycle with level 1..FIFO_DEPTH-1: level unchanged.
  - Push into empty with rready=1: the entry appears on the next edge and is not popped in the push cycle.
  - rready while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - overrun_clr has priority over a new overrun in the same cycle and clears the flag.

Test Plan:
- H=4, 8N1, send 0xA5 then 0x3C back-to-back -> two entries in order, rperr=0, rferr=0, level=2. Pop both -> rvalid=0.
- PARITY=1, send 0x07 with parity bit 0 -> rdata=0x07, rperr=1. Same byte with parity bit 1 -> rperr=0.
- rxd low pulse of H-1 clocks, then high -> no push, state returns to IDLE, level=0.
- Single-clock glitch inside data bit 3 of 0x00 -> majority rejects it, rdata=0x00.
- Stop bit driven 0, line held low 5 bit times, then released -> exactly one entry with rferr=1 and no further frames. The next frame 0x55 is received correctly.
- FIFO_DEPTH=4, send 5 frames without popping -> level=4, overrun=1, entries hold frames 1-4. Pulse overrun_clr -> overrun=0. Assert rstn low mid-frame -> level=0 and no partial push.
